// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised scratchpad with byte-lane stores,
// extended sub-word loads and a one-entry response buffer.
// state    | meaning
// ST_EMPTY | no response held, request side always ready
// ST_FULL  | response held until rsp_ready, refilled back-to-back on accept
module dmem_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic        req_is_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t                state;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           rd_word;
  logic [3:0]            rsp_be;
  logic                  rsp_signed;
  logic                  rsp_load;
  logic                  accept;
  logic                  lane_ok;
  logic                  range_ok;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           wdata_placed;

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign word_idx  = req_addr[ADDR_WIDTH+1:2];
  assign range_ok  = (req_addr >> (ADDR_WIDTH + 2)) == 32'd0;
  assign req_err   = !(lane_ok && range_ok);

  always_comb begin
    lane_ok = 1'b0;
    case ({req_addr[1:0], req_be})
      6'b00_0001, 6'b01_0010, 6'b10_0100, 6'b11_1000,
      6'b00_0011, 6'b10_1100,
      6'b00_1111: lane_ok = 1'b1;
      default:    lane_ok = 1'b0;
    endcase
  end

  // Replicate narrow store data so the byte enables alone pick the lane.
  always_comb begin
    case (req_be)
      4'b1111:          wdata_placed = req_wdata;
      4'b0011, 4'b1100: wdata_placed = {2{req_wdata[15:0]}};
      default:          wdata_placed = {4{req_wdata[7:0]}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int k = 0; k < 4; k++) begin
        if (req_be[k]) mem[word_idx][8*k +: 8] <= wdata_placed[8*k +: 8];
      end
    end
    if (accept && !req_we) rd_word <= mem[word_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_EMPTY;
      rsp_valid  <= 1'b0;
      rsp_error  <= 1'b0;
      rsp_be     <= 4'b0000;
      rsp_signed <= 1'b0;
      rsp_load   <= 1'b0;
    end else if (accept) begin
      state      <= ST_FULL;
      rsp_valid  <= 1'b1;
      rsp_error  <= req_err;
      rsp_be     <= req_be;
      rsp_signed <= req_is_signed;
      rsp_load   <= !req_we && !req_err;
    end else begin
      case (state)
        ST_FULL: begin
          if (rsp_ready) begin
            state     <= ST_EMPTY;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_load  <= 1'b0;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  // Lane select from held registers only, so data stays stable under backpressure.
  always_comb begin
    rsp_rdata = 32'd0;
    if (rsp_valid && rsp_load) begin
      case (rsp_be)
        4'b0001: rsp_rdata = {{24{rsp_signed & rd_word[7]}},  rd_word[7:0]};
        4'b0010: rsp_rdata = {{24{rsp_signed & rd_word[15]}}, rd_word[15:8]};
        4'b0100: rsp_rdata = {{24{rsp_signed & rd_word[23]}}, rd_word[23:16]};
        4'b1000: rsp_rdata = {{24{rsp_signed & rd_word[31]}}, rd_word[31:24]};
        4'b0011: rsp_rdata = {{16{rsp_signed & rd_word[15]}}, rd_word[15:0]};
        4'b1100: rsp_rdata = {{16{rsp_signed & rd_word[31]}}, rd_word[31:16]};
        4'b1111: rsp_rdata = rd_word;
        default: rsp_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected
// responses; a monitor pops and compares on each response handshake.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic        req_is_signed;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] sb[$];
  logic [32:0] mon_exp;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_be(req_be), .req_is_signed(req_is_signed),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got %h want no response", rsp_rdata);
      end else begin
        mon_exp = sb.pop_front();
        check("rsp_rdata", rsp_rdata, mon_exp[31:0]);
        check("rsp_error", {31'd0, rsp_error}, {31'd0, mon_exp[32]});
      end
    end
  end

  task automatic send(input string name, input logic [31:0] addr, input logic we,
                      input logic [3:0] be, input logic sgn, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e);
    bit done = 1'b0;
    req_valid = 1'b1; req_addr = addr; req_we = we; req_be = be;
    req_is_signed = sgn; req_wdata = wd;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        sb.push_back({exp_e, exp_d});
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    req_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept: got timeout want accept", name);
    end else begin
      check({name, "_latency"}, {31'd0, rsp_valid}, 32'd1);
    end
  endtask

  task automatic drain();
    int left = 20;
    while (sb.size() != 0 && left > 0) begin
      @(posedge clk);
      left--;
    end
    #1;
    check("drain_pending", sb.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
    req_be = '0; req_is_signed = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
    #12;
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_error", {31'd0, rsp_error}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    send("st0",      32'h0,    1, 4'hF, 0, 32'h0,        32'h0,        0);
    send("st_word",  32'h10,   1, 4'hF, 0, 32'hDEADBEEF, 32'h0,        0);
    send("ld_word",  32'h10,   0, 4'hF, 0, 32'h0,        32'hDEADBEEF, 0);
    send("ld_b3s",   32'h13,   0, 4'h8, 1, 32'h0,        32'hFFFFFFDE, 0);
    send("ld_b3u",   32'h13,   0, 4'h8, 0, 32'h0,        32'h000000DE, 0);
    send("ld_h1s",   32'h12,   0, 4'hC, 1, 32'h0,        32'hFFFFDEAD, 0);
    send("ld_h0u",   32'h10,   0, 4'h3, 0, 32'h0,        32'h0000BEEF, 0);
    send("err_mis",  32'h11,   1, 4'hF, 0, 32'h11111111, 32'h0,        1);
    send("chk_mis",  32'h10,   0, 4'hF, 0, 32'h0,        32'hDEADBEEF, 0);
    send("err_rng",  32'h1000, 1, 4'hF, 0, 32'hCAFEF00D, 32'h0,        1);
    send("chk_rng",  32'h10,   0, 4'hF, 0, 32'h0,        32'hDEADBEEF, 0);
    send("chk_alias",32'h0,    0, 4'hF, 0, 32'h0,        32'h0,        0);
    send("err_be",   32'h10,   1, 4'h6, 0, 32'hFFFFFFFF, 32'h0,        1);
    send("chk_be",   32'h10,   0, 4'hF, 0, 32'h0,        32'hDEADBEEF, 0);
    send("err_ldbe", 32'h10,   0, 4'h6, 0, 32'h0,        32'h0,        1);
    send("st_byte",  32'h11,   1, 4'h2, 0, 32'h123456AA, 32'h0,        0);
    send("ld_merge", 32'h10,   0, 4'hF, 0, 32'h0,        32'hDEADAAEF, 0);
    send("ld_b1s",   32'h11,   0, 4'h2, 1, 32'h0,        32'hFFFFFFAA, 0);
    send("st_half",  32'h2,    1, 4'hC, 0, 32'h00008001, 32'h0,        0);
    send("ld_h1s_b", 32'h2,    0, 4'hC, 1, 32'h0,        32'hFFFF8001, 0);
    send("ld_w0",    32'h0,    0, 4'hF, 0, 32'h0,        32'h80010000, 0);
    send("ld_h0s",   32'h0,    0, 4'h3, 1, 32'h0,        32'h00000000, 0);
    drain();

    rsp_ready = 1'b0;
    send("bp_a", 32'h10, 0, 4'hF, 0, 32'h0, 32'hDEADAAEF, 0);
    fork
      send("bp_b", 32'h13, 0, 4'h8, 0, 32'h0, 32'h000000DE, 0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_req_ready", {31'd0, req_ready}, 32'd0);
          check("bp_hold_rdata", rsp_rdata, 32'hDEADAAEF);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_b_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_b_rdata", rsp_rdata, 32'h000000DE);
      end
    join
    drain();

    rsp_ready = 1'b0;
    send("rst_ld", 32'h10, 0, 4'hF, 0, 32'h0, 32'hDEADAAEF, 0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst_req_ready", {31'd0, req_ready}, 32'd1);
    check("arst_rdata", rsp_rdata, 32'd0);
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    rsp_ready = 1'b1;
    send("post_rst", 32'h10, 0, 4'hF, 0, 32'h0, 32'hDEADAAEF, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
